// File: rtl/fnd_disp_scheduler.sv
// ---------------------------------------------------------------------------
// fnd_disp_scheduler
//
// Sequences the 4-digit FND display path. It chooses the display source
// (hw_sel / disp_sel) that steers the BCD mux, times the per-digit scan,
// drives the anodes with an anti-ghosting blank at the start of each slot,
// and produces the decimal-point blink.
//
// Button presses update a pending selection immediately. That selection is
// committed to o_hw_sel / o_disp_sel only at a frame boundary (digit index
// wrapping 3 -> 0), so a single frame never mixes two sources.
//
// Ports
//   clk            in   1  system clock
//   rst            in   1  synchronous active-high reset
//   i_btn_mode     in   1  1-cycle pulse: advance source mode
//   i_btn_disp     in   1  1-cycle pulse: toggle sub-display (watch/stopwatch)
//   o_hw_sel       out  2  committed source: 00 watch, 01 stopwatch,
//                          10 sr04, 11 dht11
//   o_disp_sel     out  1  committed sub-display: 0 ms view, 1 mh view
//   o_digit_idx    out  2  digit currently scanned, 0..3
//   o_fnd_com      out  4  anode drive, active-low one-hot, 4'b1111 = blank
//   o_digit_strobe out  1  1-cycle pulse on the first cycle of each new slot
//   o_dp_blink     out  1  decimal-point blink, 50% duty
//   o_dbg_state    out  3  debug view of the mode FSM: {pend_disp, pend_sel}
//
// There are no valid/ready handshakes. The buttons are single-cycle
// qualifiers and are acted on in the cycle they are high.
// ---------------------------------------------------------------------------
module fnd_disp_scheduler #(
   parameter int CLK_HZ    = 100_000_000,
   parameter int SCAN_HZ   = 1000,
   parameter int BLANK_CYC = 16,
   parameter int BLINK_HZ  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       i_btn_mode,
   input  logic       i_btn_disp,
   output logic [1:0] o_hw_sel,
   output logic       o_disp_sel,
   output logic [1:0] o_digit_idx,
   output logic [3:0] o_fnd_com,
   output logic       o_digit_strobe,
   output logic       o_dp_blink,
   output logic [2:0] o_dbg_state
);

   localparam int SLOT     = CLK_HZ / SCAN_HZ;
   localparam int SLOT_W   = (SLOT > 1) ? $clog2(SLOT) : 1;
   localparam int BLINK_TC = CLK_HZ / (2 * BLINK_HZ);
   localparam int BLINK_W  = (BLINK_TC > 1) ? $clog2(BLINK_TC) : 1;

   typedef enum logic [1:0] {
      MODE_WATCH     = 2'b00,
      MODE_STOPWATCH = 2'b01,
      MODE_SR04      = 2'b10,
      MODE_DHT11     = 2'b11
   } mode_t;

   // ------------------------------------------------------------------
   // Mode FSM (pending selection)
   // ------------------------------------------------------------------
   mode_t pend_sel, pend_sel_nxt;
   logic  pend_disp, pend_disp_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         pend_sel  <= MODE_WATCH;
         pend_disp <= 1'b0;
      end else begin
         pend_sel  <= pend_sel_nxt;
         pend_disp <= pend_disp_nxt;
      end
   end

   always_comb begin
      pend_sel_nxt  = pend_sel;
      pend_disp_nxt = pend_disp;
      if (i_btn_mode) begin
         // A mode press wins; a coincident disp press is dropped.
         unique case (pend_sel)
            MODE_WATCH:     pend_sel_nxt = MODE_STOPWATCH;
            MODE_STOPWATCH: pend_sel_nxt = MODE_SR04;
            MODE_SR04:      pend_sel_nxt = MODE_DHT11;
            MODE_DHT11:     pend_sel_nxt = MODE_WATCH;
            default:        pend_sel_nxt = MODE_WATCH;
         endcase
         // The sensor views have no sub-display, so clear it on entry.
         // Moving between watch and stopwatch keeps it.
         if (pend_sel_nxt == MODE_SR04 || pend_sel_nxt == MODE_DHT11)
            pend_disp_nxt = 1'b0;
      end else if (i_btn_disp &&
                   (pend_sel == MODE_WATCH || pend_sel == MODE_STOPWATCH)) begin
         pend_disp_nxt = ~pend_disp;
      end
   end

   assign o_dbg_state = {pend_disp, pend_sel};

   // ------------------------------------------------------------------
   // Scan timing and anode drive
   // ------------------------------------------------------------------
   logic [SLOT_W-1:0] slot_cnt, slot_nxt;
   logic [1:0]        idx_nxt;
   logic              slot_wrap, frame_wrap;
   logic [3:0]        com_nxt;

   always_comb begin
      slot_wrap  = (slot_cnt == SLOT_W'(SLOT - 1));
      slot_nxt   = slot_wrap ? '0 : slot_cnt + SLOT_W'(1);
      idx_nxt    = slot_wrap ? o_digit_idx + 2'd1 : o_digit_idx;
      frame_wrap = slot_wrap && (o_digit_idx == 2'd3);
      // The anode is computed from the next counter values so that the
      // registered output lines up with the slot/index it belongs to.
      if (slot_nxt < SLOT_W'(BLANK_CYC))
         com_nxt = 4'b1111;
      else
         com_nxt = ~(4'b0001 << idx_nxt);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         slot_cnt       <= '0;
         o_digit_idx    <= 2'd0;
         o_fnd_com      <= 4'b1111;
         o_digit_strobe <= 1'b0;
         o_hw_sel       <= 2'b00;
         o_disp_sel     <= 1'b0;
      end else begin
         slot_cnt       <= slot_nxt;
         o_digit_idx    <= idx_nxt;
         o_fnd_com      <= com_nxt;
         o_digit_strobe <= slot_wrap;
         // Commit the registered pending values. A press sampled on this
         // same edge updates pend only and is committed one frame later.
         if (frame_wrap) begin
            o_hw_sel   <= pend_sel;
            o_disp_sel <= pend_disp;
         end
      end
   end

   // ------------------------------------------------------------------
   // Decimal-point blink, free running
   // ------------------------------------------------------------------
   logic [BLINK_W-1:0] blink_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         blink_cnt  <= '0;
         o_dp_blink <= 1'b0;
      end else if (blink_cnt == BLINK_W'(BLINK_TC - 1)) begin
         blink_cnt  <= '0;
         o_dp_blink <= ~o_dp_blink;
      end else begin
         blink_cnt  <= blink_cnt + BLINK_W'(1);
      end
   end

endmodule

// File: tb/tb_fnd_disp_scheduler.sv
// ---------------------------------------------------------------------------
// tb_fnd_disp_scheduler
//
// Directed bench for fnd_disp_scheduler. Parameters are CLK_HZ=1000,
// SCAN_HZ=100 (10-cycle slot), BLANK_CYC=2 and BLINK_HZ=10 (toggle every
// 50 cycles). cyc counts cycles since the last reset edge, so cycle 0 is
// the first cycle after reset. Inputs change and outputs are sampled on
// the falling edge.
// ---------------------------------------------------------------------------
module tb_fnd_disp_scheduler;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       btn_mode = 1'b0;
   logic       btn_disp = 1'b0;
   logic [1:0] hw_sel;
   logic       disp_sel;
   logic [1:0] digit_idx;
   logic [3:0] fnd_com;
   logic       digit_strobe;
   logic       dp_blink;
   logic [2:0] dbg_state;

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   fnd_disp_scheduler #(
      .CLK_HZ(1000), .SCAN_HZ(100), .BLANK_CYC(2), .BLINK_HZ(10)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .i_btn_mode     (btn_mode),
      .i_btn_disp     (btn_disp),
      .o_hw_sel       (hw_sel),
      .o_disp_sel     (disp_sel),
      .o_digit_idx    (digit_idx),
      .o_fnd_com      (fnd_com),
      .o_digit_strobe (digit_strobe),
      .o_dp_blink     (dp_blink),
      .o_dbg_state    (dbg_state)
   );

   // clock / reset-relative cycle counter
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   // driver tasks
   task automatic at_cyc(input int n);
      @(negedge clk);
      while (cyc < n) @(negedge clk);
   endtask

   // Drives a single-cycle pulse in the current cycle. Returns at the
   // falling edge of the following cycle.
   task automatic pulse(input logic m, input logic d);
      btn_mode = m;
      btn_disp = d;
      @(negedge clk);
      btn_mode = 1'b0;
      btn_disp = 1'b0;
   endtask

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=%b expected=%b (cyc %0d)", tag, obs, exp, cyc);
      end
   endtask

   initial begin
      // test 1: reset values and the scan pattern
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;                      // current cycle is cycle 0
      chk("rst_com",    fnd_com,            4'b1111);
      chk("rst_idx",    4'(digit_idx),      4'd0);
      chk("rst_strobe", 4'(digit_strobe),   4'd0);
      chk("rst_hw",     4'(hw_sel),         4'd0);
      chk("rst_disp",   4'(disp_sel),       4'd0);
      chk("rst_blink",  4'(dp_blink),       4'd0);
      at_cyc(1);  chk("c1_com",  fnd_com, 4'b1111);
      at_cyc(2);  chk("c2_com",  fnd_com, 4'b1110);
      at_cyc(9);  chk("c9_com",  fnd_com, 4'b1110);
                  chk("c9_strobe", 4'(digit_strobe), 4'd0);
      at_cyc(10); chk("c10_idx", 4'(digit_idx), 4'd1);
                  chk("c10_strobe", 4'(digit_strobe), 4'd1);
                  chk("c10_com", fnd_com, 4'b1111);
      at_cyc(11); chk("c11_strobe", 4'(digit_strobe), 4'd0);
      at_cyc(12); chk("c12_com", fnd_com, 4'b1101);

      // test 2: a mode press mid-frame is held until the frame boundary
      at_cyc(15); pulse(1'b1, 1'b0);
      chk("c16_pend", 4'(dbg_state), 4'b0001);
      chk("c16_hw",   4'(hw_sel),    4'd0);
      at_cyc(22); chk("c22_com", fnd_com, 4'b1011);
                  chk("c22_idx", 4'(digit_idx), 4'd2);
      at_cyc(32); chk("c32_com", fnd_com, 4'b0111);
                  chk("c32_idx", 4'(digit_idx), 4'd3);
      at_cyc(39); chk("c39_com", fnd_com, 4'b0111);
                  chk("c39_hw",  4'(hw_sel), 4'd0);
      at_cyc(40); chk("c40_idx", 4'(digit_idx), 4'd0);
                  chk("c40_strobe", 4'(digit_strobe), 4'd1);
                  chk("c40_com", fnd_com, 4'b1111);
                  chk("c40_hw",  4'(hw_sel), 4'd1);
      at_cyc(49); chk("c49_blink", 4'(dp_blink), 4'd0);
      at_cyc(50); chk("c50_blink", 4'(dp_blink), 4'd1);

      // test 3: five presses in one frame, 01 + 5 = 10 (mod 4)
      at_cyc(51); pulse(1'b1, 1'b0);
      at_cyc(53); pulse(1'b1, 1'b0);
      at_cyc(55); pulse(1'b1, 1'b0);
      at_cyc(57); pulse(1'b1, 1'b0);
      at_cyc(59); pulse(1'b1, 1'b0);
      at_cyc(79); chk("c79_hw", 4'(hw_sel), 4'd1);
      at_cyc(80); chk("c80_hw", 4'(hw_sel), 4'd2);
                  chk("c80_disp", 4'(disp_sel), 4'd0);

      // test 4: disp ignored in sr04, honoured in watch and kept into stopwatch
      at_cyc(85); pulse(1'b0, 1'b1);
      chk("c86_pend", 4'(dbg_state), 4'b0010);
      at_cyc(87); pulse(1'b1, 1'b0);   // -> 11
      at_cyc(89); pulse(1'b1, 1'b0);   // -> 00
      at_cyc(91); pulse(1'b0, 1'b1);   // disp -> 1
      chk("c92_pend", 4'(dbg_state), 4'b0100);
      at_cyc(99);  chk("c99_blink", 4'(dp_blink), 4'd1);
      at_cyc(100); chk("c100_blink", 4'(dp_blink), 4'd0);
      at_cyc(119); chk("c119_hw", 4'(hw_sel), 4'd2);
                   chk("c119_disp", 4'(disp_sel), 4'd0);
      at_cyc(120); chk("c120_hw", 4'(hw_sel), 4'd0);
                   chk("c120_disp", 4'(disp_sel), 4'd1);
      at_cyc(121); pulse(1'b1, 1'b0);  // 00 -> 01, disp preserved
      at_cyc(160); chk("c160_hw", 4'(hw_sel), 4'd1);
                   chk("c160_disp", 4'(disp_sel), 4'd1);
      at_cyc(161); pulse(1'b1, 1'b0);  // 01 -> 10, disp forced 0
      at_cyc(163); pulse(1'b0, 1'b1);  // ignored in 10
      chk("c164_pend", 4'(dbg_state), 4'b0010);
      at_cyc(200); chk("c200_hw", 4'(hw_sel), 4'd2);
                   chk("c200_disp", 4'(disp_sel), 4'd0);

      // test 5: simultaneous mode and disp in mode 00
      at_cyc(201); pulse(1'b1, 1'b0);  // -> 11
      at_cyc(203); pulse(1'b1, 1'b0);  // -> 00
      at_cyc(205); pulse(1'b1, 1'b1);  // -> 01, disp dropped
      chk("c206_pend", 4'(dbg_state), 4'b0001);
      at_cyc(240); chk("c240_hw", 4'(hw_sel), 4'd1);
                   chk("c240_disp", 4'(disp_sel), 4'd0);
      at_cyc(250); chk("c250_blink", 4'(dp_blink), 4'd1);

      // a press sampled on the wrap edge commits one frame later
      at_cyc(279); pulse(1'b1, 1'b0);
      chk("c280_idx", 4'(digit_idx), 4'd0);
      chk("c280_strobe", 4'(digit_strobe), 4'd1);
      chk("c280_hw", 4'(hw_sel), 4'd1);
      chk("c280_pend", 4'(dbg_state), 4'b0010);
      at_cyc(320); chk("c320_hw", 4'(hw_sel), 4'd2);

      // test 6: reset mid-slot discards pending presses, restarts blink
      at_cyc(345); pulse(1'b1, 1'b0);  // -> 11
      at_cyc(360); chk("c360_hw", 4'(hw_sel), 4'd3);
                   chk("c360_blink", 4'(dp_blink), 4'd1);
      at_cyc(361); pulse(1'b1, 1'b0);  // -> 00
      pulse(1'b1, 1'b0);               // pulse in 362 -> 01
      chk("c363_pend", 4'(dbg_state), 4'b0001);
      chk("c363_com", fnd_com, 4'b1110);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;                      // new cycle 0
      chk("r2_com",    fnd_com,          4'b1111);
      chk("r2_idx",    4'(digit_idx),    4'd0);
      chk("r2_strobe", 4'(digit_strobe), 4'd0);
      chk("r2_hw",     4'(hw_sel),       4'd0);
      chk("r2_disp",   4'(disp_sel),     4'd0);
      chk("r2_blink",  4'(dp_blink),     4'd0);
      chk("r2_pend",   4'(dbg_state),    4'b0000);
      at_cyc(10); chk("r2_c10_idx", 4'(digit_idx), 4'd1);
      at_cyc(40); chk("r2_c40_hw", 4'(hw_sel), 4'd0);
                  chk("r2_c40_idx", 4'(digit_idx), 4'd0);
      at_cyc(49); chk("r2_c49_blink", 4'(dp_blink), 4'd0);
      at_cyc(50); chk("r2_c50_blink", 4'(dp_blink), 4'd1);

      // final report
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
